// File: rtl/pipe_ctrl_stage.sv
// pipe_ctrl_stage: two-entry skid-buffered pipeline register with flush and saturating flush counter
module pipe_ctrl_stage #(
  parameter int                DATA_W    = 96,
  parameter logic [DATA_W-1:0] FLUSH_VAL = '0,
  parameter int                CNT_W     = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occupancy,
  output logic [CNT_W-1:0]  flush_count
);
  logic              skid_valid, in_xfer, load, ov_n, sv_n;
  logic [DATA_W-1:0] skid_data, od_n, sd_n;
  assign in_ready = !skid_valid;
  // next main/skid contents: main refills from skid first so word order is kept
  always_comb begin
    in_xfer = in_valid && !skid_valid;
    load    = !out_valid || out_ready;
    ov_n    = load ? (skid_valid || in_xfer) : 1'b1;
    od_n    = !load ? out_data : skid_valid ? skid_data : in_xfer ? in_data : out_data;
    sv_n    = load ? (skid_valid && in_xfer) : (skid_valid || in_xfer);
    sd_n    = (in_xfer && (!load || skid_valid)) ? in_data : skid_data;
  end
  // state registers; reset beats flush, flush beats handshakes
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      out_valid  <= 1'b0;
      skid_valid <= 1'b0;
      out_data   <= FLUSH_VAL;
      skid_data  <= FLUSH_VAL;
      occupancy  <= 2'd0;
    end else begin
      out_valid  <= ov_n;
      skid_valid <= sv_n;
      out_data   <= od_n;
      skid_data  <= sd_n;
      occupancy  <= 2'(ov_n) + 2'(sv_n);
    end
  end
  // flush event counter, saturating at all-ones
  always_ff @(posedge clk) begin
    if (rst) flush_count <= '0;
    else if (flush && !(&flush_count)) flush_count <= flush_count + 1'b1;
  end
endmodule

// File: tb/tb_pipe_ctrl_stage.sv
// tb_pipe_ctrl_stage: directed and randomized checks against a queue-based reference model
module tb_pipe_ctrl_stage;
  localparam int DW = 96;
  logic          clk = 0, rst, flush, in_valid, in_ready, out_valid, out_ready;
  logic [DW-1:0] in_data, out_data;
  logic [1:0]    occupancy;
  logic [1:0]    flush_count;
  int            checks = 0, failures = 0;
  logic [DW-1:0] q[$];
  int            fc = 0;
  bit            zk = 0;
  int            sat_exp[5] = '{1, 2, 3, 3, 3};

  pipe_ctrl_stage #(.DATA_W(DW), .CNT_W(2)) dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .occupancy(occupancy), .flush_count(flush_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic r, input logic f, input logic iv, input logic [DW-1:0] d, input logic ordy);
    int n;
    rst = r; flush = f; in_valid = iv; in_data = d; out_ready = ordy;
    @(posedge clk);
    n = q.size();
    if (r) begin
      q.delete(); fc = 0; zk = 1;
    end else if (f) begin
      q.delete(); fc = (fc < 3) ? fc + 1 : 3; zk = 1;
    end else begin
      if (n > 0 && ordy) void'(q.pop_front());
      if (iv && n < 2) begin q.push_back(d); zk = 0; end
    end
    #1;
    chk("out_valid", out_valid, q.size() > 0);
    chk("in_ready", in_ready, q.size() < 2);
    chk("occupancy", occupancy, q.size());
    chk("flush_count", flush_count, fc);
    if (q.size() > 0) chk("out_data", out_data, q[0]);
    else if (zk) chk("out_data_flushval", out_data, 0);
  endtask

  initial begin
    step(1, 0, 0, 0, 0);
    chk("reset_in_ready", in_ready, 1);
    for (int i = 1; i <= 4; i++) begin
      step(0, 0, 1, DW'(i), 1);
      chk("stream_data", out_data, i);
      chk("stream_occ", occupancy, 1);
    end
    step(0, 0, 0, 0, 1);
    step(0, 0, 1, 'hA, 0);
    chk("bp_occ1", occupancy, 1);
    step(0, 0, 1, 'hB, 0);
    chk("bp_occ2", occupancy, 2);
    chk("bp_in_ready", in_ready, 0);
    step(0, 0, 1, 'hC, 0);
    chk("bp_hold", out_data, 'hA);
    step(0, 0, 1, 'hC, 1);
    chk("bp_out_b", out_data, 'hB);
    step(0, 0, 1, 'hC, 1);
    chk("bp_out_c", out_data, 'hC);
    step(0, 0, 0, 0, 1);
    chk("bp_drained", out_valid, 0);
    step(0, 0, 1, 'hA, 0);
    step(0, 0, 1, 'hB, 0);
    step(0, 0, 0, 0, 1);
    chk("simul_data", out_data, 'hB);
    chk("simul_occ", occupancy, 1);
    step(0, 0, 1, 'hA, 0);
    step(0, 0, 1, 'hB, 0);
    step(0, 1, 1, 'hD, 0);
    chk("flush_data", out_data, 0);
    chk("flush_cnt", flush_count, 1);
    chk("flush_ready", in_ready, 1);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 1);
    step(1, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) begin
      step(0, 1, 0, 0, 0);
      chk("sat_cnt", flush_count, sat_exp[i]);
    end
    step(0, 0, 1, 'h11, 0);
    step(0, 0, 1, 'h22, 0);
    step(1, 1, 1, 'h33, 1);
    chk("rst_cnt", flush_count, 0);
    chk("rst_valid", out_valid, 0);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 1);
    for (int i = 0; i < 600; i++)
      step($urandom_range(99) == 0, $urandom_range(19) == 0, 1'($urandom),
           {$urandom, $urandom, $urandom}, $urandom_range(3) != 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/pipe_ctrl_stage.md
PIPE_CTRL_STAGE -- requirements
Module: pipe_ctrl_stage

Interface
REQ-001 Parameter DATA_W, default 96, width of the bundled control word (alu op, srcs, dest, enables, imm, pc value).
REQ-002 Parameter FLUSH_VAL, default 0, value driven onto out_data when the stage is cleared.
REQ-003 Parameter CNT_W, default 16, width of the flush event counter.
REQ-004 The block SHALL use one clock and a synchronous, active-high reset.
REQ-005 The ports SHALL be, in order:
- clk  in  1  clock; all state updates on its rising edge.
- rst  in  1  synchronous active-high reset.
- flush  in  1  discard all held and incoming words this cycle.
- in_valid  in  1  upstream word present.
- in_ready  out  1  stage accepts a word this cycle.
- in_data  in  DATA_W  upstream control word.
- out_valid  out  1  out_data holds a valid word.
- out_ready  in  1  downstream consumes out_data this cycle.
- out_data  out  DATA_W  registered control word.
- occupancy  out  2  words held, 0..2.
- flush_count  out  CNT_W  saturating count of flush events.

Function
REQ-006 Storage SHALL be one main register (out_data/out_valid) plus one skid register (skid_data/skid_valid); no combinational path from in_data to out_data.
REQ-007 in_ready SHALL equal !skid_valid, driven from a register only (no dependence on out_ready in the same cycle).
REQ-008 Input transfer SHALL occur when in_valid && in_ready; output transfer SHALL occur when out_valid && out_ready.
REQ-009 Main register loads when !out_valid || out_ready: from skid if skid_valid (skid then empties), else from in_data if an input transfer occurs, else out_valid goes 0.
REQ-010 When main register cannot load (out_valid && !out_ready) and an input transfer occurs, in_data SHALL be written to skid, skid_valid=1.
REQ-011 When the main register loads from skid and an input transfer occurs in the same cycle, in_data SHALL be written to skid (skid stays valid); order of words SHALL be preserved.
REQ-012 Latency: a word accepted into an empty stage SHALL appear on out_data with out_valid=1 the next cycle.
REQ-013 Throughput SHALL be one word per cycle when out_ready is held high.
REQ-014 States by (out_valid, skid_valid): EMPTY(0,0), ONE(1,0), FULL(1,1); (0,1) SHALL never occur.
REQ-015 occupancy SHALL equal out_valid + skid_valid, registered.
REQ-016 While out_valid && !out_ready, out_data SHALL remain stable.
REQ-017 flush=1 SHALL, at the next edge, set out_valid=0, skid_valid=0, out_data=FLUSH_VAL, skid_data=FLUSH_VAL; any input transfer in that cycle is discarded; any output transfer in that cycle still counts as consumed downstream.
REQ-018 flush SHALL take priority over all handshake activity in the same cycle; in_ready SHALL be 1 the cycle after a flush.
REQ-019 flush_count SHALL increment by 1 on each cycle with flush=1 and saturate at 2^CNT_W-1 (no wrap).
REQ-020 Invalid words SHALL not be required to hold FLUSH_VAL except directly after flush or reset.

Reset
REQ-021 rst=1 SHALL, at the next edge, set out_valid=0, skid_valid=0, out_data=FLUSH_VAL, skid_data=FLUSH_VAL, occupancy=0, flush_count=0, in_ready=1.
REQ-022 rst SHALL take priority over flush and all handshakes; a flush in the reset cycle SHALL not be counted.
REQ-023 Reset mid-operation SHALL discard all held words with no output transfer in following cycles until new input.

Verification
REQ-024 Streaming: out_ready=1, in_valid=1, in_data=1,2,3,4 on consecutive cycles -> out_data 1,2,3,4 one cycle later each, occupancy=1, in_ready=1 throughout.
REQ-025 Backpressure: out_ready=0, push 0xA then 0xB -> occupancy 1 then 2, in_ready=0, 0xC held at input not accepted; release out_ready -> outputs 0xA,0xB,0xC in order, none lost or duplicated.
REQ-026 Simultaneous: FULL with 0xA/0xB, out_ready=1 and in_valid=0 -> next cycle out_data=0xB, occupancy=1, in_ready=1.
REQ-027 Flush while FULL with in_valid=1, in_data=0xD -> next cycle out_valid=0, occupancy=0, out_data=0, flush_count=1, in_ready=1; 0xD never appears at output.
REQ-028 Saturation: CNT_W=2, flush high 5 cycles -> flush_count 1,2,3,3,3.
REQ-029 Reset mid-stream while FULL with flush=1 -> all outputs at reset values, flush_count=0.
